vga_pixel_engine: RTL and testbench



---
 rtl/vga_pixel_engine.sv | 175 +++++++++++++++++
 tb/tb_vga_pixel_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_engine.sv
// rtl/vga_pixel_engine.sv - VGA raster engine with prefetch unpacking and test patterns
//
// Ports:
//   clk, resetn                  pixel clock, synchronous active-low reset
//   en_i                         engine enable; low idles outputs and empties buffers
//   mode_i                       0 frame data, 1 colour bars, 2 solid, 3 checker
//   solid_i                      solid colour {R,G,B}
//   h*_i / v*_i                  horizontal / vertical timing points
//   data_i, data_valid_i         packed pixel word from the frame buffer
//   data_req_o                   prefetch slot free
//   red_o, green_o, blue_o       registered colour
//   hsync_o, vsync_o, blank_o    registered sync and active-video flag
//   frame_start_o                pulse aligned with the first pixel of a frame
//   underrun_o                   sticky starvation flag
module vga_pixel_engine #(
    parameter int COLOR_W   = 4,
    parameter int PIX_W     = 16,
    parameter int DATA_W    = 64,
    parameter int CNT_W     = 12,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int BAR_SHIFT = 6,
    parameter int CHK_SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en_i,
    input  logic [1:0]             mode_i,
    input  logic [3*COLOR_W-1:0]   solid_i,
    input  logic [CNT_W-1:0]       hsync_end_i,
    input  logic [CNT_W-1:0]       hpulse_end_i,
    input  logic [CNT_W-1:0]       hdata_begin_i,
    input  logic [CNT_W-1:0]       hdata_end_i,
    input  logic [CNT_W-1:0]       vsync_end_i,
    input  logic [CNT_W-1:0]       vpulse_end_i,
    input  logic [CNT_W-1:0]       vdata_begin_i,
    input  logic [CNT_W-1:0]       vdata_end_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   data_valid_i,
    output logic                   data_req_o,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   blank_o,
    output logic                   frame_start_o,
    output logic                   underrun_o
);

    localparam int   PPW    = DATA_W / PIX_W;
    localparam int   PIDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int   RGB_W  = 3 * COLOR_W;
    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    logic [CNT_W-1:0]  hcnt, vcnt;
    logic [1:0]        mode_q;
    logic              mode_ok;   // a frame origin has latched mode_q since enable
    logic [DATA_W-1:0] cur_q, nxt_q;
    logic              cur_v, nxt_v;
    logic [PIDX_W-1:0] pidx;

    logic              frame_origin, active, last_px;
    logic [1:0]        mode_now;
    logic [CNT_W-1:0]  x, y, xy;
    logic [2:0]        bar_idx;
    logic [RGB_W-1:0]  px_rgb;
    logic              take_cur, take_nxt;

    assign frame_origin = (hcnt == '0) && (vcnt == '0);
    // The origin pixel already uses the newly sampled mode.
    assign mode_now     = frame_origin ? mode_i : mode_q;
    assign active       = (hcnt >= hdata_begin_i) && (hcnt < hdata_end_i) &&
                          (vcnt >= vdata_begin_i) && (vcnt < vdata_end_i);
    assign last_px      = (hcnt == hdata_end_i - CNT_W'(1)) &&
                          (vcnt == vdata_end_i - CNT_W'(1));
    assign x            = hcnt - hdata_begin_i;
    assign y            = vcnt - vdata_begin_i;
    assign xy           = x ^ y;
    assign bar_idx      = 3'(x >> BAR_SHIFT);
    assign data_req_o   = en_i && mode_ok && (mode_q == 2'd0) && !nxt_v;

    always_comb begin
        px_rgb   = '0;
        take_cur = 1'b0;
        take_nxt = 1'b0;
        case (mode_now)
            2'd0: begin
                if (cur_v) begin
                    px_rgb   = cur_q[int'(pidx)*PIX_W +: RGB_W];
                    take_cur = 1'b1;
                end else if (nxt_v) begin
                    px_rgb   = nxt_q[RGB_W-1:0];
                    take_nxt = 1'b1;
                end
            end
            2'd1:    px_rgb = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
            2'd2:    px_rgb = solid_i;
            default: px_rgb = {RGB_W{xy[CHK_SHIFT]}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn || !en_i) begin
            hcnt          <= '0;
            vcnt          <= '0;
            mode_q        <= 2'd0;
            mode_ok       <= 1'b0;
            cur_q         <= '0;
            nxt_q         <= '0;
            cur_v         <= 1'b0;
            nxt_v         <= 1'b0;
            pidx          <= '0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            hsync_o       <= ~HS_ACT;
            vsync_o       <= ~VS_ACT;
            blank_o       <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            if (hcnt == hsync_end_i) begin
                hcnt <= '0;
                vcnt <= (vcnt == vsync_end_i) ? '0 : vcnt + CNT_W'(1);
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end

            if (frame_origin) begin
                mode_q  <= mode_i;
                mode_ok <= 1'b1;
            end

            frame_start_o <= frame_origin;
            hsync_o       <= (hcnt < hpulse_end_i) ? HS_ACT : ~HS_ACT;
            vsync_o       <= (vcnt < vpulse_end_i) ? VS_ACT : ~VS_ACT;
            blank_o       <= active;
            {red_o, green_o, blue_o} <= active ? px_rgb : '0;

            if (active && mode_now == 2'd0) begin
                if (take_cur) begin
                    if (pidx == PIDX_W'(PPW - 1)) begin
                        cur_v <= 1'b0;
                        pidx  <= '0;
                    end else begin
                        pidx <= pidx + PIDX_W'(1);
                    end
                end else if (take_nxt) begin
                    // Pixel 0 goes out now; a one-pixel word is used up at once.
                    cur_q <= nxt_q;
                    cur_v <= (PPW > 1);
                    pidx  <= (PPW > 1) ? PIDX_W'(1) : '0;
                    nxt_v <= 1'b0;
                end else begin
                    underrun_o <= 1'b1;
                end
            end

            // Frame end drops the partly shown word so the next frame starts word-aligned.
            if (active && last_px) begin
                cur_v <= 1'b0;
                pidx  <= '0;
            end

            // Placed last so a reload wins over the clear from a promotion.
            if (data_valid_i && data_req_o) begin
                nxt_q <= data_i;
                nxt_v <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_engine.sv
// tb/tb_vga_pixel_engine.sv - scoreboard bench for vga_pixel_engine
module tb_vga_pixel_engine;

    logic        clk = 1'b0;
    logic        resetn, en_i, data_valid_i, data_req_o;
    logic [1:0]  mode_i;
    logic [11:0] solid_i;
    logic [11:0] hsync_end_i, hpulse_end_i, hdata_begin_i, hdata_end_i;
    logic [11:0] vsync_end_i, vpulse_end_i, vdata_begin_i, vdata_end_i;
    logic [63:0] data_i;
    logic [3:0]  red_o, green_o, blue_o;
    logic        hsync_o, vsync_o, blank_o, frame_start_o, underrun_o;

    // Small raster: 600 clocks/line, 6 lines, 512x2 active, 3600 clocks/frame.
    localparam int FRAME = 3600;

    vga_pixel_engine dut (
        .clk(clk), .resetn(resetn), .en_i(en_i), .mode_i(mode_i), .solid_i(solid_i),
        .hsync_end_i(hsync_end_i), .hpulse_end_i(hpulse_end_i),
        .hdata_begin_i(hdata_begin_i), .hdata_end_i(hdata_end_i),
        .vsync_end_i(vsync_end_i), .vpulse_end_i(vpulse_end_i),
        .vdata_begin_i(vdata_begin_i), .vdata_end_i(vdata_end_i),
        .data_i(data_i), .data_valid_i(data_valid_i), .data_req_o(data_req_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o),
        .frame_start_o(frame_start_o), .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic        src_on = 1'b0;
    int          src_w  = 0;
    logic [11:0] bar_rgb [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                                 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel n of the source stream; n=0..3 are 123, 456, 789, ABC.
    function automatic logic [11:0] pv(input int n);
        return 12'(32'h123 + n * 32'h333);
    endfunction

    function automatic logic [63:0] word(input int w);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[k*16 +: 16] = {4'h0, pv(w*4 + k)};
        return d;
    endfunction

    // Source: always-valid when on; a word is consumed at the edge where req was high.
    initial begin
        logic hs_pending;
        hs_pending   = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (hs_pending) src_w++;
            data_valid_i = src_on;
            data_i       = word(src_w);
            hs_pending   = src_on && data_req_o;
        end
    end

    // Monitor: every active pixel is compared against the next expected colour.
    always @(negedge clk) begin
        if (blank_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pixel_unexpected: got %0h expected none", {red_o, green_o, blue_o});
            end else begin
                chk("pixel", {red_o, green_o, blue_o}, exp_q.pop_front());
            end
        end
    end

    task automatic run(input int n, output int hs, output int vs, output int bl, output int fs);
        hs = 0; vs = 0; bl = 0; fs = 0;
        repeat (n) begin
            @(negedge clk);
            if (!hsync_o) hs++;
            if (!vsync_o) vs++;
            if (blank_o) bl++;
            if (frame_start_o) fs++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rgb"}, {red_o, green_o, blue_o}, 0);
        chk({tag, "_hsync"}, hsync_o, 1);
        chk({tag, "_vsync"}, vsync_o, 1);
        chk({tag, "_blank"}, blank_o, 0);
        chk({tag, "_req"}, data_req_o, 0);
        chk({tag, "_fstart"}, frame_start_o, 0);
        chk({tag, "_underrun"}, underrun_o, 0);
    endtask

    task automatic idle(input int n);
        en_i   = 1'b0;
        src_on = 1'b0;
        repeat (n) @(negedge clk);
        src_w = 0;
    endtask

    initial begin
        int hs, vs, bl, fs;
        resetn = 1'b0; en_i = 1'b0; mode_i = 2'd0; solid_i = 12'h000;
        hsync_end_i = 12'd599; hpulse_end_i = 12'd48; hdata_begin_i = 12'd60; hdata_end_i = 12'd572;
        vsync_end_i = 12'd5;   vpulse_end_i = 12'd1;  vdata_begin_i = 12'd2;  vdata_end_i = 12'd4;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        resetn = 1'b1;
        idle(2);
        chk("disabled_req", data_req_o, 0);

        // Solid colour: sync widths, active count and colour.
        mode_i = 2'd2; solid_i = 12'hF00;
        for (int i = 0; i < 1024; i++) exp_q.push_back(12'hF00);
        en_i = 1'b1;
        run(FRAME, hs, vs, bl, fs);
        chk("solid_hsync_low", hs, 6*48);
        chk("solid_vsync_low", vs, 600);
        chk("solid_blank_cnt", bl, 1024);
        chk("solid_fstart_cnt", fs, 1);
        chk("solid_queue_left", exp_q.size(), 0);
        idle(3);
        chk("idle_blank", blank_o, 0);
        chk("idle_hsync", hsync_o, 1);

        // Frame data from an always-valid source.
        mode_i = 2'd0;
        for (int i = 0; i < 1024; i++) exp_q.push_back(pv(i));
        src_on = 1'b1; en_i = 1'b1;
        run(FRAME, hs, vs, bl, fs);
        chk("data_underrun", underrun_o, 0);
        chk("data_queue_left", exp_q.size(), 0);
        idle(3);

        // Starved source: black active pixels, sticky underrun cleared by disable.
        mode_i = 2'd0;
        for (int i = 0; i < 1024; i++) exp_q.push_back(12'h000);
        en_i = 1'b1;
        run(FRAME, hs, vs, bl, fs);
        chk("starve_blank_cnt", bl, 1024);
        chk("starve_underrun", underrun_o, 1);
        run(10, hs, vs, bl, fs);
        chk("starve_underrun_held", underrun_o, 1);
        idle(1);
        chk("starve_underrun_clr", underrun_o, 0);
        chk("starve_queue_left", exp_q.size(), 0);
        idle(2);

        // Colour bars, 64 pixels per bar.
        mode_i = 2'd1;
        for (int l = 0; l < 2; l++)
            for (int x = 0; x < 512; x++) exp_q.push_back(bar_rgb[x >> 6]);
        en_i = 1'b1;
        run(FRAME, hs, vs, bl, fs);
        chk("bars_queue_left", exp_q.size(), 0);
        idle(3);

        // Mode 0 -> 3 changed mid-frame: data frame, then checker frame.
        mode_i = 2'd0;
        for (int i = 0; i < 1024; i++) exp_q.push_back(pv(i));
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 512; x++)
                exp_q.push_back((((x ^ y) >> 5) & 1) != 0 ? 12'hFFF : 12'h000);
        src_on = 1'b1; en_i = 1'b1;
        run(100, hs, vs, bl, fs);
        mode_i = 2'd3;
        run(2*FRAME - 100, hs, vs, bl, fs);
        chk("switch_fstart_cnt", fs, 1);
        chk("switch_queue_left", exp_q.size(), 0);
        idle(3);

        // One-cycle reset mid-line.
        mode_i = 2'd2; solid_i = 12'h0F0;
        en_i = 1'b1;
        run(700, hs, vs, bl, fs);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset_fstart", frame_start_o, 1);
        chk("midreset_hsync", hsync_o, 0);
        chk("midreset_vsync", vsync_o, 0);
        idle(2);
        chk("final_queue_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
